joystick_debounce: RTL and testbench



---
 rtl/joystick_debounce_if.sv | 25 ++
 rtl/joystick_debounce.sv | 88 ++++++++
 tb/tb_joystick_debounce.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/joystick_debounce_if.sv
// Joystick pin/vector bundle between the raw Pmod pins and the debounced mainboard inputs.
// The debouncer takes the slave view; whatever drives the pins takes the master view.
interface joystick_debounce_if;
  logic [0:4] joy1_pins;
  logic [0:4] joy2_pins;
  logic [0:4] joy1;
  logic [0:4] joy2;
  logic       joy_changed;

  modport master (
    output joy1_pins,
    output joy2_pins,
    input  joy1,
    input  joy2,
    input  joy_changed
  );

  modport slave (
    input  joy1_pins,
    input  joy2_pins,
    output joy1,
    output joy2,
    output joy_changed
  );
endinterface

// File: rtl/joystick_debounce.sv
// Two-flop synchronizer plus per-bit tick-paced stability counters for both DB9 ports.
// Raw active-low pins in; registered active-high vectors and a one-cycle change strobe out.
module joystick_debounce #(
  parameter int prescale     = 54,
  parameter int stable_ticks = 1000
) (
  input logic                clk,
  input logic                reset,
  joystick_debounce_if.slave joy
);
  localparam int PW = (prescale > 1) ? $clog2(prescale) : 1;
  localparam int CW = (stable_ticks > 1) ? $clog2(stable_ticks) : 1;
  localparam int NB = 10;

  logic [0:NB-1] pins;
  logic [0:NB-1] sync;
  logic [0:NB-1] upd;
  logic [0:NB-1] s1_q;
  logic [0:NB-1] s2_q;
  logic [0:NB-1] out_q;
  logic [0:NB-1] out_d;
  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic          tick;
  logic          changed_q;
  logic          changed_d;

  // Port 1 occupies indices 0..4, port 2 indices 5..9, preserving pin order.
  assign pins = {joy.joy1_pins, joy.joy2_pins};
  assign sync = ~s2_q;
  assign tick = (pre_q == PW'(prescale - 1));

  // Next-state for prescaler, per-bit counters, outputs and strobe.
  always_comb begin
    if (tick) begin
      pre_d = {PW{1'b0}};
    end else begin
      pre_d = pre_q + PW'(1);
    end
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      out_d[i] = out_q[i];
      upd[i]   = 1'b0;
      // A match always wins over a tick, so any bounce back restarts qualification.
      if (sync[i] == out_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (tick && (cnt_q[i] == CW'(stable_ticks - 1))) begin
        out_d[i] = sync[i];
        cnt_d[i] = {CW{1'b0}};
        upd[i]   = 1'b1;
      end else if (tick) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    changed_d = |upd;
  end

  // State registers; synchronizer resets to the released (high) pin level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= {NB{1'b1}};
      s2_q      <= {NB{1'b1}};
      out_q     <= {NB{1'b0}};
      pre_q     <= {PW{1'b0}};
      changed_q <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      s1_q      <= pins;
      s2_q      <= s1_q;
      out_q     <= out_d;
      pre_q     <= pre_d;
      changed_q <= changed_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign joy.joy1        = out_q[0:4];
  assign joy.joy2        = out_q[5:9];
  assign joy.joy_changed = changed_q;
endmodule

// File: tb/tb_joystick_debounce.sv
// Directed and randomized bench for joystick_debounce (prescale=4, stable_ticks=3),
// checked each cycle against a tick-counting reference model plus latency windows.
module tb_joystick_debounce;
  localparam int P  = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   ecnt     = 0;

  joystick_debounce_if jif ();

  joystick_debounce #(.prescale(P), .stable_ticks(ST)) dut (
    .clk   (clk),
    .reset (reset),
    .joy   (jif)
  );

  always #5 clk = ~clk;

  // Reference model: sync is the pin level two edges old, inverted; an output follows
  // once ST ticks have been seen inside one unbroken run of sync != out.
  logic [0:9] hist1, hist2, m_out;
  logic       m_changed;
  int         n;
  int         tickq [10][$];

  task automatic model_edge();
    logic [0:9] sync;
    logic       tk;
    logic       any;
    if (reset) begin
      hist1 = '1; hist2 = '1; m_out = '0; m_changed = 1'b0; n = 0;
      for (int i = 0; i < 10; i++) tickq[i].delete();
    end else begin
      sync = ~hist2;
      tk   = ((n % P) == P - 1);
      any  = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (sync[i] == m_out[i]) begin
          tickq[i].delete();
        end else if (tk) begin
          tickq[i].push_back(n);
          if (tickq[i].size() == ST) begin
            m_out[i] = sync[i];
            tickq[i].delete();
            any = 1'b1;
          end
        end
      end
      m_changed = any;
      hist2 = hist1;
      hist1 = {jif.joy1_pins, jif.joy2_pins};
      n++;
    end
  endtask

  task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at edge %0d", tag, obs, exp, ecnt);
    end
  endtask

  task automatic cmp_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    ecnt++;
    @(negedge clk);
    cmp("joy1", jif.joy1, m_out[0:4]);
    cmp("joy2", jif.joy2, m_out[5:9]);
    cmp("joy_changed", {4'b0000, jif.joy_changed}, {4'b0000, m_changed});
  endtask

  initial begin
    int base, first, f2, pulses, pedge, trans, seen;
    logic prev;

    // Reset state
    reset = 1'b1;
    jif.joy1_pins = 5'b11111;
    jif.joy2_pins = 5'b11111;
    @(negedge clk);
    cycle();
    cmp("reset_joy1", jif.joy1, 5'b00000);
    cmp("reset_joy2", jif.joy2, 5'b00000);
    cmp("reset_chg", {4'b0000, jif.joy_changed}, 5'b00000);
    cycle();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (jif.joy1 !== 5'b00000 || jif.joy2 !== 5'b00000 || jif.joy_changed !== 1'b0) seen++;
    end
    cmp_range("idle_after_reset", seen, 0, 0);

    // Clean press
    jif.joy1_pins = 5'b01111;
    base = ecnt; first = -1; pulses = 0; pedge = -1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (first < 0 && jif.joy1 === 5'b10000) first = ecnt - base;
      if (jif.joy_changed === 1'b1) begin pulses++; pedge = ecnt - base; end
    end
    cmp_range("press_latency", first, 11, 14);
    cmp_range("press_pulses", pulses, 1, 1);
    cmp_range("press_pulse_edge", pedge, first, first);
    cmp("press_joy2", jif.joy2, 5'b00000);
    jif.joy1_pins = 5'b11111;
    for (int k = 0; k < 20; k++) cycle();

    // Glitch rejection
    pulses = 0; seen = 0;
    jif.joy2_pins[3] = 1'b0;
    for (int k = 0; k < 36; k++) begin
      if (k == 6) jif.joy2_pins[3] = 1'b1;
      cycle();
      if (jif.joy_changed === 1'b1) pulses++;
      if (jif.joy2 !== 5'b00000) seen++;
    end
    cmp_range("glitch_pulses", pulses, 0, 0);
    cmp_range("glitch_joy2", seen, 0, 0);

    // Bounce then hold low
    trans = 0; prev = 1'b0;
    for (int k = 0; k < 30; k++) begin
      jif.joy1_pins[2] = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
      cycle();
      if (jif.joy1[2] !== prev) begin trans++; prev = jif.joy1[2]; end
    end
    jif.joy1_pins[2] = 1'b0;
    base = ecnt; first = -1;
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (jif.joy1[2] !== prev) begin trans++; prev = jif.joy1[2]; end
      if (first < 0 && jif.joy1[2] === 1'b1) first = ecnt - base;
    end
    cmp_range("bounce_transitions", trans, 1, 1);
    cmp_range("bounce_latency", first, 11, 14);
    jif.joy1_pins = 5'b11111;
    for (int k = 0; k < 20; k++) cycle();

    // Simultaneous release
    jif.joy1_pins = 5'b01110;
    jif.joy2_pins = 5'b11011;
    for (int k = 0; k < 20; k++) cycle();
    cmp("held_joy1", jif.joy1, 5'b10001);
    cmp("held_joy2", jif.joy2, 5'b00100);
    jif.joy1_pins = 5'b11111;
    jif.joy2_pins = 5'b11111;
    base = ecnt; first = -1; f2 = -1; pulses = 0;
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (first < 0 && jif.joy1 === 5'b00000) first = ecnt - base;
      if (f2 < 0 && jif.joy2 === 5'b00000) f2 = ecnt - base;
      if (jif.joy_changed === 1'b1) pulses++;
    end
    cmp_range("release_latency", first, 11, 14);
    cmp_range("release_same_edge", f2, first, first);
    cmp_range("release_pulses", pulses, 1, 1);

    // Reset mid-qualification
    jif.joy1_pins[1] = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    reset = 1'b1;
    cycle();
    cmp("midreset_joy1", jif.joy1, 5'b00000);
    reset = 1'b0;
    base = ecnt; first = -1;
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (first < 0 && jif.joy1[1] === 1'b1) first = ecnt - base;
    end
    cmp_range("midreset_latency", first, 11, 14);
    jif.joy1_pins = 5'b11111;
    for (int k = 0; k < 20; k++) cycle();

    // Randomized pin activity with occasional reset
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7, 0) == 0) begin
        int b;
        b = $urandom_range(9, 0);
        if (b < 5) jif.joy1_pins[b] = ~jif.joy1_pins[b];
        else       jif.joy2_pins[b - 5] = ~jif.joy2_pins[b - 5];
      end
      reset = ($urandom_range(499, 0) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
